srlzr_tx_sched: RTL and testbench



---
 rtl/srlzr_tx_sched_pkg.sv | 19 +
 rtl/srlzr_tx_sched_if.sv | 30 +++
 rtl/srlzr_tx_sched_rr_arbiter.sv | 29 ++
 rtl/srlzr_tx_sched.sv | 135 +++++++++++++
 tb/tb_srlzr_tx_sched.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/srlzr_tx_sched_pkg.sv
// Shared definitions for the serializer transmit scheduler: FSM state
// encodings and a width helper usable in constant expressions.
package srlzr_tx_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // Minimum result of 1 so a counter or index never collapses to zero bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/srlzr_tx_sched_if.sv
// Bundle between the word sources and the serializer: request handshake on
// one side, load/shift strobes and status on the other.
interface srlzr_tx_sched_if
  import srlzr_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int GID_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          ser_valid;
  logic [DATA_WIDTH-1:0]         ser_data;
  logic                          ser_shift;
  logic [GID_W-1:0]              grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_valid, ser_data, ser_shift, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_valid, ser_data, ser_shift, grant_id, busy
  );

endinterface

// File: rtl/srlzr_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first active request strictly after
// last_grant, wrapping to index 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_grant,
  output logic [GID_W-1:0]   grant,
  output logic               any_req
);

  // Wrap by compare so non-power-of-two NUM_REQ still rotates correctly.
  always_comb begin : pick
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = GID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/srlzr_tx_sched.sv
// Round-robin scheduler sharing one PISO serializer among NUM_REQ sources:
// arbitrate, load one word, pace DATA_WIDTH shifts, idle gap, repeat.
module srlzr_tx_sched
  import srlzr_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  srlzr_tx_sched_if.slave  bus
);

  localparam int GID_W = clog2(NUM_REQ);
  localparam int DIV_W = clog2(CLKS_PER_BIT);
  localparam int BIT_W = clog2(DATA_WIDTH + 1);
  localparam int GAP_W = clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NUM_REQ - 1);

  logic [2:0]            state_q,      state_d;
  logic [GID_W-1:0]      grant_id_q,   grant_id_d;
  logic [GID_W-1:0]      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] ser_data_q,   ser_data_d;
  logic [DIV_W-1:0]      div_cnt_q,    div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;

  logic [GID_W-1:0]      arb_grant;
  logic                  arb_any;
  logic                  load_ok;
  logic                  shift;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  assign load_ok  = bus.req_valid[grant_id_q];
  assign sel_data = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign shift    = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    ser_data_d   = ser_data_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: if (|bus.req_valid) state_d = ST_ARB;
      ST_ARB: begin
        if (arb_any) begin
          grant_id_d = arb_grant;
          state_d    = ST_LOAD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      // Pointer advances even on a withdrawn load so a flaky source cannot hog priority.
      ST_LOAD: begin
        last_grant_d = grant_id_q;
        div_cnt_d    = '0;
        bit_cnt_d    = '0;
        if (load_ok) begin
          ser_data_d = sel_data;
          state_d    = ST_SHIFT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_INIT;
      ser_data_q   <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      ser_data_q   <= ser_data_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == ST_LOAD) bus.req_ready[grant_id_q] = 1'b1;
  end

  assign bus.ser_valid = (state_q == ST_LOAD) && load_ok;
  assign bus.ser_shift = shift;
  assign bus.ser_data  = ser_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_srlzr_tx_sched.sv
// Directed bench for srlzr_tx_sched: a table of word transfers checked for
// grant order, data and strobe timing, plus hand-written corner sequences.
module tb_srlzr_tx_sched;

  logic clk;
  logic rst;
  int   vec_count;
  int   miscompares;

  srlzr_tx_sched_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  srlzr_tx_sched #(
    .DATA_WIDTH   (8),
    .NUM_REQ      (4),
    .CLKS_PER_BIT (4),
    .GAP_CYCLES   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[10];

  localparam logic [31:0] ALL_DATA = 32'h44332211;

  task automatic check_output(input string name, input int act, input int exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycle 0 is the negedge in IDLE where valid is already presented.
  task automatic run_word(input logic [1:0] g, input logic [7:0] d,
                          input int inj_at, input logic [3:0] inj_val);
    int cyc, sv_cyc, first_sh, last_sh, prev_sh, n_sh;
    int ready_bad, space_bad, overlap, idle_cyc;
    logic [7:0] data_seen;
    cyc = 0; sv_cyc = -1; first_sh = -1; last_sh = -1; prev_sh = -1;
    n_sh = 0; ready_bad = 0; space_bad = 0; overlap = 0; idle_cyc = -1;
    data_seen = 8'h00;
    while (sv_cyc < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.ser_valid) sv_cyc = cyc;
    end
    check_output("load_latency", sv_cyc, 2);
    check_output("grant_id", int'(bus.grant_id), int'(g));
    check_output("req_ready_onehot", int'(bus.req_ready), int'(4'b0001 << g));
    check_output("no_shift_on_load", int'(bus.ser_shift), 0);
    while (idle_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj_at) bus.req_valid = inj_val;
      if (cyc == 3) data_seen = bus.ser_data;
      if (bus.req_ready != 4'b0000) ready_bad++;
      if (bus.ser_shift) begin
        if (bus.ser_valid) overlap++;
        if (prev_sh >= 0 && (cyc - prev_sh) != 4) space_bad++;
        if (first_sh < 0) first_sh = cyc;
        prev_sh = cyc;
        last_sh = cyc;
        n_sh++;
      end
      if (!bus.busy) idle_cyc = cyc;
    end
    check_output("ser_data", int'(data_seen), int'(d));
    check_output("first_shift_cycle", first_sh, 6);
    check_output("last_shift_cycle", last_sh, 34);
    check_output("shift_count", n_sh, 8);
    check_output("shift_spacing_errors", space_bad, 0);
    check_output("ready_outside_load", ready_bad + overlap, 0);
    check_output("idle_cycle", idle_cyc, 37);
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [31:0] data);
    bus.req_valid = valid;
    bus.req_data  = data;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_sh, cnt, act_cnt;
    vec_count   = 0;
    miscompares = 0;

    vecs[0] = '{4'b0001, 32'h000000A5, 2'd0, 8'hA5};
    vecs[1] = '{4'b1111, ALL_DATA,     2'd1, 8'h22};
    vecs[2] = '{4'b1111, ALL_DATA,     2'd2, 8'h33};
    vecs[3] = '{4'b1111, ALL_DATA,     2'd3, 8'h44};
    vecs[4] = '{4'b1111, ALL_DATA,     2'd0, 8'h11};
    vecs[5] = '{4'b1111, ALL_DATA,     2'd1, 8'h22};
    vecs[6] = '{4'b1010, ALL_DATA,     2'd3, 8'h44};
    vecs[7] = '{4'b1010, ALL_DATA,     2'd1, 8'h22};
    vecs[8] = '{4'b0100, ALL_DATA,     2'd2, 8'h33};
    vecs[9] = '{4'b0011, ALL_DATA,     2'd0, 8'h11};

    rst = 1'b1;
    apply_stimulus(4'b0000, 32'h0);
    repeat (3) @(negedge clk);
    check_output("reset_outputs",
                 int'({bus.req_ready, bus.ser_valid, bus.ser_data, bus.ser_shift,
                       bus.grant_id, bus.busy}), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data);
      run_word(vecs[i].exp_grant, vecs[i].exp_data, 0, 4'b0000);
    end

    // Withdrawn valid: granted in ARB, dropped during LOAD.
    apply_stimulus(4'b0100, ALL_DATA);
    @(negedge clk);
    check_output("withdraw_arb_busy", int'(bus.busy), 1);
    @(negedge clk);
    check_output("withdraw_load_sv_before", int'(bus.ser_valid), 1);
    bus.req_valid = 4'b0000;
    #1;
    check_output("withdraw_load_sv_after", int'(bus.ser_valid), 0);
    check_output("withdraw_load_ready", int'(bus.req_ready), 4);
    @(negedge clk);
    check_output("withdraw_back_idle", int'(bus.busy), 0);
    check_output("withdraw_data_kept", int'(bus.ser_data), 8'h11);

    // All valids drop during ARB: straight back to IDLE, no LOAD.
    apply_stimulus(4'b0001, ALL_DATA);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check_output("arb_drop_idle", int'({bus.busy, bus.req_ready, bus.ser_valid}), 0);

    // Requester 0 shows up mid-SHIFT while 1 is serialized; served next.
    apply_stimulus(4'b0010, ALL_DATA);
    run_word(2'd1, 8'h22, 10, 4'b0011);
    run_word(2'd0, 8'h11, 0, 4'b0000);

    // Reset after three shifts aborts the word and restores priority to 0.
    apply_stimulus(4'b0100, ALL_DATA);
    n_sh = 0;
    cnt  = 0;
    while (n_sh < 3 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bus.ser_shift) n_sh++;
    end
    check_output("pre_reset_shifts", n_sh, 3);
    rst = 1'b1;
    #1;
    check_output("reset_mid_shift_outputs",
                 int'({bus.req_ready, bus.ser_valid, bus.ser_data, bus.ser_shift,
                       bus.grant_id, bus.busy}), 0);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    act_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ser_shift || bus.busy) act_cnt++;
    end
    check_output("post_reset_quiet", act_cnt, 0);
    apply_stimulus(4'b1111, ALL_DATA);
    run_word(2'd0, 8'h11, 0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
